// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage load/store responder driving an asynchronous SRAM with a fixed-length access.
// Handshake: o_ready=1 means no access is pending; while o_ready=0 the pipeline must hold its request stable.
module mem_stage_sram_ctrl #(
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_en,
  input  logic              i_wr_en,
  input  logic [31:0]       i_address,
  input  logic [DATA_W-1:0] i_write_data,
  output logic [DATA_W-1:0] o_read_data,
  output logic              o_ready,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic [1:0]        o_state
);

  localparam int               CNT_W   = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [31:0]      LP_BASE = 32'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_read_data;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_wdata;
  logic              r_sram_we_n;
  logic              r_sram_oe_n;
  logic              w_ready;
  logic              w_start;
  logic              w_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Stall is combinational in IDLE so the request cycle itself already freezes the pipeline.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_start      = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = ~(i_rd_en | i_wr_en);
        w_start = i_rd_en | i_wr_en;
        if (w_start) begin
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_last = (r_cnt == LP_LAST);
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_ready      = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_read_data  <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_sram_we_n  <= 1'b1;
      r_sram_oe_n  <= 1'b1;
    end else if (w_start) begin
      r_cnt       <= '0;
      r_sram_addr <= ADDR_W'((i_address - LP_BASE) >> 2);
      // A simultaneous read and write is treated as a write only.
      if (i_wr_en) begin
        r_sram_wdata <= i_write_data;
        r_sram_we_n  <= 1'b0;
      end else begin
        r_sram_oe_n <= 1'b0;
      end
    end else if (r_state == S_ACCESS) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        if (!r_sram_oe_n) begin
          r_read_data <= i_sram_rdata;
        end
        r_sram_we_n <= 1'b1;
        r_sram_oe_n <= 1'b1;
      end
    end
  end

  assign o_ready      = w_ready;
  assign o_read_data  = r_read_data;
  assign o_sram_addr  = r_sram_addr;
  assign o_sram_wdata = r_sram_wdata;
  assign o_sram_we_n  = r_sram_we_n;
  assign o_sram_oe_n  = r_sram_oe_n;
  assign o_state      = r_state;

endmodule
